// File: rtl/quick_spi_pkg.sv
// Shared definitions for the quick_spi burst sequencer: byte width, default filler
// byte and the burst FSM state encoding.
package quick_spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] FILLER_DEFAULT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_DATA,
    ST_HOLD
  } burst_state_e;

endpackage

// File: rtl/quick_spi_sync_fifo.sv
// Single-clock first-word fall-through FIFO with registered full/empty flags.
// Simultaneous push and pop both take effect; popping an empty FIFO does nothing.
module quick_spi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic             pop_en_c;
  logic             push_en_c;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
  assign pop_en_c  = pop_i & ~empty_q;
  assign push_en_c = push_i & (~full_q | pop_en_c);

  always_comb begin
    count_d = count_q;
    case ({push_en_c, pop_en_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_en_c) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_en_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == CW'(0));
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/quick_spi_burst_ctrl.sv
// Burst sequencer in front of the quick_spi byte master: owns chip select, feeds one
// byte per start from the TX FIFO and collects returned bytes into the RX FIFO.
module quick_spi_burst_ctrl
  import quick_spi_pkg::*;
#(
  parameter int unsigned            TX_DEPTH = 16,
  parameter int unsigned            RX_DEPTH = 16,
  parameter int unsigned            CS_SETUP = 2,
  parameter int unsigned            CS_HOLD  = 2,
  parameter logic [SPI_BYTE_W-1:0]  FILLER   = FILLER_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [7:0]            burst_len,
  input  logic                  go,
  output logic                  busy,
  output logic                  done,
  output logic                  rx_overflow,
  output logic                  cs_n,
  output logic                  spi_start,
  output logic [SPI_BYTE_W-1:0] spi_data_in,
  input  logic [SPI_BYTE_W-1:0] spi_data_out,
  input  logic                  spi_busy,
  input  logic                  spi_new_data
);

  localparam int unsigned CNT_W = 16;

  burst_state_e          state_q, state_d;
  logic [7:0]            remain_q, remain_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cs_n_q, cs_n_d;
  logic                  start_q, start_d;
  logic [SPI_BYTE_W-1:0] data_in_q, data_in_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  rx_push_q, rx_push_d;
  logic [SPI_BYTE_W-1:0] rx_wdata_q, rx_wdata_d;

  logic [SPI_BYTE_W-1:0] tx_head_c;
  logic                  tx_full_c;
  logic                  tx_empty_c;
  logic                  tx_pop_c;
  logic                  rx_full_c;
  logic                  rx_empty_c;

  quick_spi_sync_fifo #(
    .WIDTH (SPI_BYTE_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (tx_pop_c),
    .rdata_o (tx_head_c),
    .full_o  (tx_full_c),
    .empty_o (tx_empty_c)
  );

  quick_spi_sync_fifo #(
    .WIDTH (SPI_BYTE_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (rx_push_q),
    .wdata_i (rx_wdata_q),
    .pop_i   (rx_ready),
    .rdata_o (rx_data),
    .full_o  (rx_full_c),
    .empty_o (rx_empty_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      remain_q   <= '0;
      cnt_q      <= '0;
      cs_n_q     <= 1'b1;
      start_q    <= 1'b0;
      data_in_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rx_push_q  <= 1'b0;
      rx_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      cnt_q      <= cnt_d;
      cs_n_q     <= cs_n_d;
      start_q    <= start_d;
      data_in_q  <= data_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      rx_push_q  <= rx_push_d;
      rx_wdata_q <= rx_wdata_d;
    end
  end

  // Pin outputs are decoded from the current state and so trail it by one cycle.
  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    cnt_d      = cnt_q;
    data_in_d  = data_in_q;
    ovf_d      = ovf_q;
    rx_push_d  = 1'b0;
    rx_wdata_d = rx_wdata_q;
    tx_pop_c   = 1'b0;
    cs_n_d     = (state_q == ST_IDLE);
    start_d    = (state_q == ST_LOAD);
    done_d     = (state_q == ST_IDLE) && !cs_n_q;

    if (rx_push_q && rx_full_c && !rx_ready) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (go && (burst_len != 8'd0)) begin
          state_d  = ST_SETUP;
          remain_d = burst_len;
          cnt_d    = '0;
          ovf_d    = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        data_in_d = tx_empty_c ? FILLER : tx_head_c;
        tx_pop_c  = !tx_empty_c;
        state_d   = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (spi_busy) begin
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (spi_new_data) begin
          rx_push_d  = 1'b1;
          rx_wdata_d = spi_data_out;
          remain_d   = remain_q - 8'd1;
          cnt_d      = '0;
          state_d    = (remain_q == 8'd1) ? ST_HOLD : ST_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign tx_ready    = ~tx_full_c;
  assign rx_valid    = ~rx_empty_c;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rx_overflow = ovf_q;
  assign cs_n        = cs_n_q;
  assign spi_start   = start_q;
  assign spi_data_in = data_in_q;

endmodule

// File: tb/tb_quick_spi_burst_ctrl.sv
// Scoreboard bench for quick_spi_burst_ctrl with a behavioural quick_spi stand-in
// that answers every byte with the transmitted byte XOR 8'h5A.
module tb_quick_spi_burst_ctrl;

  localparam int unsigned SL_CYC = 4;
  localparam logic [7:0]  XR     = 8'h5A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] burst_len = '0;
  logic       go = 1'b0;
  logic       busy, done, rx_overflow, cs_n, spi_start;
  logic [7:0] spi_data_in;
  logic [7:0] spi_data_out;
  logic       spi_busy, spi_new_data;

  quick_spi_burst_ctrl #(
    .TX_DEPTH (16),
    .RX_DEPTH (4),
    .CS_SETUP (3),
    .CS_HOLD  (2),
    .FILLER   (8'h00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .burst_len    (burst_len),
    .go           (go),
    .busy         (busy),
    .done         (done),
    .rx_overflow  (rx_overflow),
    .cs_n         (cs_n),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_data_out (spi_data_out),
    .spi_busy     (spi_busy),
    .spi_new_data (spi_new_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  int n_start = 0, n_done = 0;
  int go_cyc = 0, fall_cyc = 0, rise_cyc = 0, start_cyc = 0, nd_cyc = 0;
  bit seen_start = 1'b0;
  logic prev_cs = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // quick_spi stand-in: busy one edge after start, new_data after SL_CYC more edges.
  logic       sl_active;
  int         sl_cnt;
  logic [7:0] sl_byte;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_busy <= 1'b0; spi_new_data <= 1'b0; spi_data_out <= '0;
      sl_active <= 1'b0; sl_cnt <= 0; sl_byte <= '0;
    end else begin
      spi_new_data <= 1'b0;
      if (!sl_active) begin
        if (spi_start) begin
          sl_active <= 1'b1; spi_busy <= 1'b1; sl_byte <= spi_data_in; sl_cnt <= 0;
        end
      end else if (sl_cnt == int'(SL_CYC) - 1) begin
        sl_active <= 1'b0; spi_busy <= 1'b0; spi_new_data <= 1'b1;
        spi_data_out <= sl_byte ^ XR;
      end else begin
        sl_cnt <= sl_cnt + 1;
      end
    end
  end

  // Monitor: compares each transmitted byte against the scoreboard and logs edge times.
  always @(negedge clk) begin
    if (prev_cs && !cs_n) begin fall_cyc = cyc; seen_start = 1'b0; end
    if (!prev_cs && cs_n) rise_cyc = cyc;
    prev_cs = cs_n;
    if (spi_new_data) nd_cyc = cyc;
    if (done) n_done++;
    if (spi_start) begin
      n_start++;
      if (!seen_start) begin start_cyc = cyc; seen_start = 1'b1; end
      check_val("cs_n_at_start", 32'(cs_n), 32'd0);
      if (exp_tx.size() == 0) check_val("unexpected_start", 32'd1, 32'd0);
      else check_val("spi_data_in", 32'(spi_data_in), 32'(exp_tx.pop_front()));
    end
  end

  task automatic push_tx(input logic [7:0] b, input bit expect_sent);
    @(negedge clk);
    tx_data = b; tx_valid = 1'b1;
    if (expect_sent) begin exp_tx.push_back(b); exp_rx.push_back(b ^ XR); end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic expect_filler(input int n);
    for (int i = 0; i < n; i++) begin exp_tx.push_back(8'h00); exp_rx.push_back(8'h00 ^ XR); end
  endtask

  task automatic start_burst(input logic [7:0] len);
    @(negedge clk);
    burst_len = len; go = 1'b1; go_cyc = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int t;
    t = 0;
    while (n_done == base && t < 400) begin @(negedge clk); #1; t++; end
    if (n_done == base) check_val({tag, "_done_timeout"}, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic drain_rx(input string tag);
    int t;
    t = 0;
    while (exp_rx.size() > 0 && t < 100) begin
      @(negedge clk);
      if (rx_valid) begin
        check_val({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx.pop_front()));
        rx_ready = 1'b1;
      end else begin
        rx_ready = 1'b0;
      end
      t++;
    end
    if (exp_rx.size() > 0) check_val({tag, "_rx_timeout"}, 32'(exp_rx.size()), 32'd0);
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "_rx_empty"}, 32'(rx_valid), 32'd0);
    exp_rx.delete();
  endtask

  initial begin
    #(200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs, bd;
    repeat (3) @(negedge clk);
    check_val("rst_cs_n", 32'(cs_n), 32'd1);
    check_val("rst_spi_start", 32'(spi_start), 32'd0);
    check_val("rst_spi_data_in", 32'(spi_data_in), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_ovf", 32'(rx_overflow), 32'd0);
    check_val("rst_tx_ready", 32'(tx_ready), 32'd1);
    check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_val("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic three-byte burst with CS timing
    push_tx(8'h6C, 1); push_tx(8'hA5, 1); push_tx(8'h3C, 1);
    bs = n_start; bd = n_done;
    start_burst(8'd3);
    wait_done(bd, "basic");
    check_val("basic_starts", 32'(n_start - bs), 32'd3);
    check_val("basic_dones", 32'(n_done - bd), 32'd1);
    check_val("go_to_cs_fall", 32'(fall_cyc - go_cyc), 32'd2);
    check_val("cs_fall_to_start", 32'(start_cyc - fall_cyc), 32'd3);
    check_val("last_nd_to_cs_rise", 32'(rise_cyc - nd_cyc), 32'd4);
    check_val("basic_busy_after", 32'(busy), 32'd0);
    drain_rx("basic");

    // filler bytes from an empty TX FIFO
    expect_filler(2);
    bd = n_done;
    start_burst(8'd2);
    wait_done(bd, "filler");
    check_val("filler_dones", 32'(n_done - bd), 32'd1);
    drain_rx("filler");

    // go while busy is ignored
    push_tx(8'h11, 1); push_tx(8'h22, 1); push_tx(8'h33, 1); push_tx(8'h44, 1);
    bs = n_start; bd = n_done;
    start_burst(8'd4);
    repeat (6) @(negedge clk);
    check_val("busy_mid_burst", 32'(busy), 32'd1);
    start_burst(8'd7);
    wait_done(bd, "busy_go");
    repeat (20) @(negedge clk);
    check_val("busy_go_starts", 32'(n_start - bs), 32'd4);
    check_val("busy_go_dones", 32'(n_done - bd), 32'd1);
    drain_rx("busy_go");

    // go with zero length is ignored
    bs = n_start; bd = n_done;
    start_burst(8'd0);
    repeat (20) @(negedge clk);
    check_val("len0_busy", 32'(busy), 32'd0);
    check_val("len0_cs_n", 32'(cs_n), 32'd1);
    check_val("len0_starts", 32'(n_start - bs), 32'd0);
    check_val("len0_dones", 32'(n_done - bd), 32'd0);

    // RX overflow: six bytes into a four-deep RX FIFO
    for (int i = 1; i <= 6; i++) begin
      push_tx(8'(i), 1);
      if (i > 4) void'(exp_rx.pop_back());
    end
    bd = n_done;
    start_burst(8'd6);
    wait_done(bd, "ovf");
    check_val("ovf_flag", 32'(rx_overflow), 32'd1);
    check_val("ovf_dones", 32'(n_done - bd), 32'd1);
    drain_rx("ovf");
    check_val("ovf_sticky", 32'(rx_overflow), 32'd1);
    expect_filler(1);
    bd = n_done;
    start_burst(8'd1);
    check_val("ovf_cleared_by_go", 32'(rx_overflow), 32'd0);
    wait_done(bd, "ovf_clr");
    drain_rx("ovf_clr");

    // TX full: sixteen bytes fill it, a seventeenth is dropped
    for (int i = 0; i < 16; i++) push_tx(8'(i * 7 + 3), 1);
    check_val("tx_full_ready", 32'(tx_ready), 32'd0);
    push_tx(8'hEE, 0);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] keep[$];
      keep = exp_rx;
      exp_rx.delete();
      for (int j = 0; j < 4; j++) exp_rx.push_back(keep.pop_front());
      bd = n_done;
      start_burst(8'd4);
      wait_done(bd, "txfull");
      drain_rx("txfull");
      exp_rx = keep;
      if (b == 0) check_val("tx_ready_after_pop", 32'(tx_ready), 32'd1);
    end
    expect_filler(1);
    bd = n_done;
    start_burst(8'd1);
    wait_done(bd, "txdrop");
    drain_rx("txdrop");

    // asynchronous reset during byte 2 of 4
    push_tx(8'hA1, 1); push_tx(8'hA2, 1); push_tx(8'hA3, 1); push_tx(8'hA4, 1);
    bs = n_start; bd = n_done;
    start_burst(8'd4);
    begin
      int t;
      t = 0;
      while (n_start - bs < 2 && t < 200) begin @(negedge clk); #1; t++; end
      check_val("rstmid_reached_byte2", 32'(n_start - bs), 32'd2);
    end
    #2;
    rst = 1'b0;
    #1;
    check_val("rstmid_cs_n", 32'(cs_n), 32'd1);
    check_val("rstmid_busy", 32'(busy), 32'd0);
    check_val("rstmid_start", 32'(spi_start), 32'd0);
    check_val("rstmid_tx_ready", 32'(tx_ready), 32'd1);
    check_val("rstmid_rx_valid", 32'(rx_valid), 32'd0);
    exp_tx.delete();
    exp_rx.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_tx(8'h81, 1);
    bs = n_start;
    start_burst(8'd1);
    wait_done(bd, "post_rst");
    check_val("post_rst_dones", 32'(n_done - bd), 32'd1);
    check_val("post_rst_starts", 32'(n_start - bs), 32'd1);
    drain_rx("post_rst");
    check_val("scoreboard_tx_empty", 32'(exp_tx.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/quick_spi_burst_ctrl.md
# quick_spi_burst_ctrl

Burst sequencer that sits directly upstream of the `quick_spi` byte-level SPI master. It buffers outgoing bytes in a TX FIFO and owns chip select. It issues one `start` per byte to `quick_spi` and collects each received byte from `data_out`/`new_data` into an RX FIFO. Host logic then sees a whole SPI transaction of N bytes as one `go` plus two byte streams.

## Interface
- `TX_DEPTH`, 16: TX FIFO depth in bytes; power of two, at least 2.
- `RX_DEPTH`, 16: RX FIFO depth in bytes; power of two, at least 2.
- `CS_SETUP`, 2: clk cycles between `cs_n` falling and the first `spi_start`; at least 1.
- `CS_HOLD`, 2: clk cycles between the last received byte and `cs_n` rising; at least 1.
- `FILLER`, 8'h00: byte sent when the TX FIFO is empty mid-burst.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; one clock domain.
- `tx_data`  in  8  byte to queue for transmission.
- `tx_valid`  in  1  push request.
- `tx_ready`  out  1  TX FIFO not full.
- `rx_data`  out  8  head of the RX FIFO (first-word fall-through).
- `rx_valid`  out  1  RX FIFO not empty.
- `rx_ready`  in  1  pop request.
- `burst_len`  in  8  bytes in the burst, 1..255; sampled on `go`.
- `go`  in  1  start-burst strobe.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse when a burst completes.
- `rx_overflow`  out  1  sticky; a received byte was dropped.
- `cs_n`  out  1  SPI slave select, active-low.
- `spi_start`  out  1  to `quick_spi.start`.
- `spi_data_in`  out  8  to `quick_spi.data_in`.
- `spi_data_out`  in  8  from `quick_spi.data_out`.
- `spi_busy`  in  1  from `quick_spi.busy`.
- `spi_new_data`  in  1  from `quick_spi.new_data`.

## Operation
- **FSM states:** IDLE, SETUP, LOAD, WAIT_BUSY, WAIT_DATA, HOLD.
- **IDLE:**
  - `go`=1 with `burst_len`≠0: latch `burst_len` into `remain`, clear `rx_overflow`, go to SETUP.
  - `go` with `burst_len`=0: ignored, no `done`.
  - `go` in any state other than IDLE: ignored.
- **SETUP:** `cs_n`=0; count `CS_SETUP` cycles, then go to LOAD.
- **LOAD:**
  - `spi_data_in` ← TX head, or `FILLER` if the TX FIFO is empty; pop the TX FIFO only if it was non-empty.
  - `spi_start`=1 for exactly this one cycle, then go to WAIT_BUSY.
- **WAIT_BUSY:** stay until `spi_busy`=1, then go to WAIT_DATA.
- **WAIT_DATA:** on `spi_new_data`=1:
  - push `spi_data_out` into the RX FIFO;
  - decrement `remain`;
  - if `remain` is now 0, go to HOLD, else go to LOAD.
- **HOLD:** `cs_n` stays 0 for `CS_HOLD` cycles, then `cs_n`=1, `done`=1 for one cycle, back to IDLE.
- **`spi_data_in`:** registered and held stable from LOAD until the next LOAD.
- **RX full on push:** the byte is discarded, `rx_overflow` is set, and the burst continues.
- **TX FIFO:** may be pushed at any time, including during a burst. Push when full is ignored (`tx_ready`=0).
- **Simultaneous push and pop** on either FIFO, full or empty: both take effect and the occupancy is unchanged. Exception: a pop of an empty FIFO is a no-op.
- **`busy`:** 1 in every state except IDLE.

## Timing
- **Reset values:** `cs_n`=1, `spi_start`=0, `spi_data_in`=0, `busy`=0, `done`=0, `rx_overflow`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0; both FIFOs empty; state IDLE.
- **Reset mid-burst:** all outputs return to their reset values immediately (asynchronous); no `done` pulse.
- **`go` to `cs_n`:** `go` sampled at edge k → `cs_n`=0 from edge k+1.
- **First `spi_start`:** asserted at edge k+1+`CS_SETUP`.
- **`spi_new_data` to RX:** `spi_new_data` at edge m → byte visible on `rx_data`/`rx_valid` after edge m+1 (if the FIFO was empty).
- **Back-to-back bytes:** `spi_new_data` at edge m → next `spi_start` at edge m+1.
- **`tx_ready`:** combinational from the FIFO full flag.
- **`rx_valid`/`rx_data`:** registered FIFO outputs.
- **`spi_new_data` and `spi_busy`:** both may fall in the same cycle; WAIT_DATA reacts to `spi_new_data` only.

## Structure
- **Shared package `quick_spi_pkg`:**
  - the FSM state enum;
  - byte width constant `SPI_BYTE_W`=8;
  - default `FILLER` value.
- **Sub-module `quick_spi_sync_fifo`:** parameterised width/depth, first-word fall-through, full/empty flags; instantiated twice (TX, RX).
- **FSM and counters** live in the top module.

## Test plan
- **Basic burst:** push 0x6C, 0xA5, 0x3C; `go` with `burst_len`=3 against `quick_spi` (`CLK_DIV`=2) in MISO loopback → three `spi_start` pulses, `spi_data_in` = 0x6C, 0xA5, 0x3C in order, RX pops the same 3 bytes, one `done`, `cs_n` low for the whole burst.
- **Filler:** empty TX FIFO, `burst_len`=2 → `spi_data_in`=0x00 twice, 2 RX bytes, `done`=1.
- **Overflow:** `RX_DEPTH`=2, `burst_len`=4, no pops → 2 bytes held, `rx_overflow`=1 after byte 3, `done` still pulses; a new `go` clears `rx_overflow`.
- **Ignored `go`:** `go` while `busy`=1, and `go` with `burst_len`=0 in IDLE → no effect, no extra `done`.
- **CS timing:** `CS_SETUP`=3, `CS_HOLD`=2 → exactly 3 cycles from `cs_n` falling to first `spi_start`; exactly 2 cycles from last `spi_new_data`+1 to `cs_n` rising.
- **Reset mid-burst:** `rst`=0 during byte 2 of 4 → `cs_n`=1 and `busy`=0 without waiting for a clock edge, FIFOs empty; a following burst of 1 byte (0x81) completes normally.
